// File: rtl/notgate_toggle.sv
// Debounced push-button toggle.
// A raw, bouncing button input is synchronized, debounced by a four-state FSM
// and used to flip a registered toggle level once per accepted press.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RELEASED    | button accepted as released, waiting for a pressed sample
// PRESS_CHK   | pressed seen, counting stable pressed cycles
// PRESSED     | button accepted as pressed, waiting for a released sample
// RELEASE_CHK | released seen, counting stable released cycles
module notgate_toggle #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic b,
  output logic a_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Raw level of a released button; the synchronizer resets to it so that
  // reset never looks like an edge.
  localparam logic             REL_RAW  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             b_q, b_d;
  logic             a_level_q, a_level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             pressed;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= REL_RAW;
      sync2_q <= REL_RAW;
    end else begin
      sync1_q <= a;
      sync2_q <= sync1_q;
    end
  end

  // Normalize to pressed = 1 regardless of button polarity.
  assign pressed = sync2_q ^ ACTIVE_LOW;

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      b_q       <= 1'b0;
      a_level_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      a_level_q <= a_level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state and next-output logic; strobes default low so each lasts one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    a_level_d = a_level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!pressed) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          b_d       = ~b_q;
          a_level_d = 1'b1;
          press_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (pressed) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          a_level_d = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign b             = b_q;
  assign a_level       = a_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_notgate_toggle.sv
// Directed bench for notgate_toggle with DEBOUNCE_CYCLES=4: one active-low
// instance and one active-high instance sharing clock and reset.
module tb_notgate_toggle;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b1;
  logic a_hi = 1'b0;
  logic b, a_level, press_pulse, release_pulse;
  logic b_hi, a_level_hi, press_pulse_hi, release_pulse_hi;

  int n_total = 0;
  int n_bad = 0;
  int np = 0, nr = 0, n_ovl = 0;
  int np_hi = 0, nr_hi = 0, n_ovl_hi = 0;
  int base_p, base_r;

  notgate_toggle #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .a_level(a_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  notgate_toggle #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .a(a_hi), .b(b_hi), .a_level(a_level_hi),
    .press_pulse(press_pulse_hi), .release_pulse(release_pulse_hi)
  );

  always #5 clk = ~clk;

  // Strobe counters sampled on the falling edge.
  always @(negedge clk) begin
    if (press_pulse) np++;
    if (release_pulse) nr++;
    if (press_pulse && release_pulse) n_ovl++;
    if (press_pulse_hi) np_hi++;
    if (release_pulse_hi) nr_hi++;
    if (press_pulse_hi && release_pulse_hi) n_ovl_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    tick(3);
    chk("rst_b", b, 0);
    chk("rst_level", a_level, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    rst_n = 1'b1;

    // released button held: nothing happens
    tick(20);
    chk("idle_b", b, 0);
    chk("idle_level", a_level, 0);
    chk("idle_np", np, 0);
    chk("idle_nr", nr, 0);

    // clean press then clean release
    a = 1'b0;
    tick(6);
    chk("press_early", press_pulse, 0);
    chk("press_early_b", b, 0);
    tick(1);
    chk("press_pulse", press_pulse, 1);
    chk("press_b", b, 1);
    chk("press_level", a_level, 1);
    tick(1);
    chk("press_pulse_end", press_pulse, 0);
    tick(10);
    a = 1'b1;
    tick(6);
    chk("rel_early", release_pulse, 0);
    chk("rel_early_level", a_level, 1);
    tick(1);
    chk("rel_pulse", release_pulse, 1);
    chk("rel_level", a_level, 0);
    chk("rel_b_kept", b, 1);
    tick(1);
    chk("rel_pulse_end", release_pulse, 0);
    chk("pair_np", np, 1);
    chk("pair_nr", nr, 1);

    // bouncing press never accepted
    do_reset();
    base_p = np; base_r = nr;
    repeat (5) begin
      a = 1'b0;
      tick(3);
      a = 1'b1;
      tick(3);
    end
    tick(10);
    chk("bounce_np", np - base_p, 0);
    chk("bounce_nr", nr - base_r, 0);
    chk("bounce_b", b, 0);
    chk("bounce_level", a_level, 0);

    // three clean press/release pairs
    do_reset();
    base_p = np; base_r = nr;
    for (int i = 0; i < 3; i++) begin
      a = 1'b0;
      tick(12);
      chk("seq_b_pressed", b, (i % 2 == 0) ? 1 : 0);
      a = 1'b1;
      tick(12);
      chk("seq_b_released", b, (i % 2 == 0) ? 1 : 0);
    end
    chk("seq_np", np - base_p, 3);
    chk("seq_nr", nr - base_r, 3);

    // reset mid-count with button held down
    do_reset();
    base_p = np;
    a = 1'b0;
    tick(5);
    chk("midrst_no_press", np - base_p, 0);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_b", b, 0);
    chk("midrst_level", a_level, 0);
    rst_n = 1'b1;
    tick(6);
    chk("midrst_b_early", b, 0);
    chk("midrst_pulse_early", press_pulse, 0);
    tick(1);
    chk("midrst_b_late", b, 1);
    chk("midrst_pulse", press_pulse, 1);
    tick(1);
    chk("midrst_np", np - base_p, 1);
    a = 1'b1;
    tick(12);

    // active-high instance: quiet so far, then one press
    chk("hi_idle_np", np_hi, 0);
    chk("hi_idle_b", b_hi, 0);
    a_hi = 1'b1;
    tick(6);
    chk("hi_press_early", press_pulse_hi, 0);
    tick(1);
    chk("hi_press_pulse", press_pulse_hi, 1);
    chk("hi_press_b", b_hi, 1);
    chk("hi_press_level", a_level_hi, 1);
    tick(1);
    chk("hi_press_end", press_pulse_hi, 0);
    chk("hi_np", np_hi, 1);

    chk("overlap", n_ovl, 0);
    chk("overlap_hi", n_ovl_hi, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
